// File: rtl/csa_accum_stage_if.sv
// Stream bundle for the carry-save accumulator: operand input channel and
// completed-group output channel toward the carry-propagate adder.
interface csa_accum_stage_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 13,
  parameter int CNT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_a;
  logic [OUT_W-1:0] out_b;
  logic [CNT_W-1:0] out_count;
  logic             out_forced;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_count, out_forced
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_a, out_b, out_count, out_forced
  );
endinterface

// File: rtl/csa_accum_stage.sv
// Carry-save accumulator: keeps a running total as (sum, carry) so no carry
// ripples per operand; hands both vectors to the downstream adder per group.
module csa_accum_stage #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 13,
  parameter int MAX_OPS = 32,
  parameter int CNT_W   = 6
) (
  input logic               clk,
  input logic               reset,
  csa_accum_stage_if.slave  bus
);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] s_q, s_d, c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_forced_q, out_forced_d;

  logic [OUT_W-1:0] x;
  logic [OUT_W-1:0] s_nx, c_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             accept, close;

  // One full-adder row per operand; the carry shift drops the top bit, which
  // the MAX_OPS bound guarantees carries no weight of the group total.
  assign x      = {{(OUT_W-IN_W){1'b0}}, bus.in_data};
  assign s_nx   = s_q ^ c_q ^ x;
  assign c_nx   = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
  assign cnt_nx = cnt_q + CNT_W'(1);
  assign accept = bus.in_valid && (state_q == ACCUM);
  assign close  = bus.in_last || (cnt_nx == CNT_W'(MAX_OPS));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= ACCUM;
      s_q          <= '0;
      c_q          <= '0;
      cnt_q        <= '0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_count_q  <= '0;
      out_forced_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      c_q          <= c_d;
      cnt_q        <= cnt_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_count_q  <= out_count_d;
      out_forced_q <= out_forced_d;
    end
  end

  always_comb begin
    // NOTE: defaults first hold every register, so no path infers a latch.
    state_d      = state_q;
    s_d          = s_q;
    c_d          = c_q;
    cnt_d        = cnt_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_count_d  = out_count_q;
    out_forced_d = out_forced_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (close) begin
            state_d      = HOLD;
            out_a_d      = s_nx;
            out_b_d      = c_nx;
            out_count_d  = cnt_nx;
            out_forced_d = !bus.in_last;
            s_d          = '0;
            c_d          = '0;
            cnt_d        = '0;
          end else begin
            s_d   = s_nx;
            c_d   = c_nx;
            cnt_d = cnt_nx;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state_q == ACCUM);
    bus.out_valid  = (state_q == HOLD);
    bus.out_a      = out_a_q;
    bus.out_b      = out_b_q;
    bus.out_count  = out_count_q;
    bus.out_forced = out_forced_q;
  end

endmodule

// File: tb/tb_csa_accum_stage.sv
// Bench for csa_accum_stage: group totals modelled as plain integer sums,
// queued on close and compared by an independent output monitor.
module tb_csa_accum_stage;

  localparam int IN_W    = 8;
  localparam int OUT_W   = 13;
  localparam int MAX_OPS = 32;
  localparam int CNT_W   = 6;

  typedef struct {
    int sum;
    int count;
    bit forced;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
  exp_t exp_q[$];
  int   m_sum = 0;
  int   m_cnt = 0;

  csa_accum_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  csa_accum_stage #(
    .IN_W(IN_W), .OUT_W(OUT_W), .MAX_OPS(MAX_OPS), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the group total is just the integer sum of its operands.
  task automatic model_add(input int d, input bit last);
    exp_t e;
    m_sum += d;
    m_cnt++;
    if (last || m_cnt == MAX_OPS) begin
      e.sum    = m_sum;
      e.count  = m_cnt;
      e.forced = !last;
      exp_q.push_back(e);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [IN_W-1:0] d, input bit last);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      model_add(int'(d), last);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = IN_W'($urandom);
    bus.in_last  = 1'($urandom);
  endtask

  task automatic drain();
    int waited = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain_timeout", int'(exp_q.size() == 0 && !bus.out_valid), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out();
    int waited = 0;
    while (!bus.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("out_valid_timeout", int'(bus.out_valid), 1);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready",   int'(bus.in_ready),   1);
    check("rst_out_valid",  int'(bus.out_valid),  0);
    check("rst_out_a",      int'(bus.out_a),      0);
    check("rst_out_b",      int'(bus.out_b),      0);
    check("rst_out_count",  int'(bus.out_count),  0);
    check("rst_out_forced", int'(bus.out_forced), 0);
  endtask

  // out_ready driver, offset from the stimulus update time to avoid races.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       bus.out_ready = 1'($urandom_range(0, 1));
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on each output handshake and checks hold-stability.
  initial begin
    bit               held = 1'b0;
    logic [OUT_W-1:0] h_a, h_b;
    logic [CNT_W-1:0] h_cnt;
    logic             h_forced;
    exp_t             e;
    int               total;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        check("ready_xor_valid", int'(bus.in_ready ^ bus.out_valid), 1);
        if (bus.out_valid) begin
          if (held) begin
            check("hold_a",      int'(bus.out_a),      int'(h_a));
            check("hold_b",      int'(bus.out_b),      int'(h_b));
            check("hold_count",  int'(bus.out_count),  int'(h_cnt));
            check("hold_forced", int'(bus.out_forced), int'(h_forced));
          end
          if (bus.out_ready) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_output", 1, 0);
            end else begin
              e = exp_q.pop_front();
              total = int'(bus.out_a) + int'(bus.out_b);
              check("group_sum_mod", total % (1 << OUT_W), e.sum % (1 << OUT_W));
              check("group_sum",     total, e.sum);
              check("sum_range",     int'(total < (1 << (OUT_W + 1))), 1);
              check("group_count",   int'(bus.out_count),  e.count);
              check("group_forced",  int'(bus.out_forced), int'(e.forced));
            end
          end else begin
            held     = 1'b1;
            h_a      = bus.out_a;
            h_b      = bus.out_b;
            h_cnt    = bus.out_count;
            h_forced = bus.out_forced;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;

    // 3,5,7: exact carry-save vectors
    ready_mode = 1;
    send(8'd3, 1'b0);
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    @(negedge clk);
    wait_out();
    check("cs357_a", int'(bus.out_a), 3);
    check("cs357_b", int'(bus.out_b), 12);
    check("cs357_count", int'(bus.out_count), 3);
    drain();

    // Single operand: one-cycle latency
    send(8'd200, 1'b1);
    @(negedge clk);
    check("single_latency", int'(bus.out_valid), 1);
    check("single_a", int'(bus.out_a), 200);
    check("single_b", int'(bus.out_b), 0);
    drain();

    // 32 x 255 with no in_last: forced close, 33rd operand stalls
    ready_mode = 2;
    for (int i = 0; i < MAX_OPS; i++) send(8'd255, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd255;
    bus.in_last  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("full_stall_ready", int'(bus.in_ready), 0);
      check("full_valid", int'(bus.out_valid), 1);
    end
    check("full_sum", int'(bus.out_a) + int'(bus.out_b), 8160);
    check("full_count", int'(bus.out_count), 32);
    check("full_forced", int'(bus.out_forced), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ready_mode = 1;
    drain();

    // Back-pressure hold, then a group that must wait for the handshake
    ready_mode = 2;
    send(8'd10, 1'b0);
    send(8'd20, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    check("bp_sum", int'(bus.out_a) + int'(bus.out_b), 30);
    @(posedge clk); #1;
    ready_mode = 1;
    send(8'd1, 1'b1);
    drain();

    // Gapped input, garbage data while in_valid is low
    for (int i = 0; i < 4; i++) begin
      repeat (2) begin
        bus.in_data = IN_W'($urandom);
        bus.in_last = 1'($urandom);
        @(posedge clk); #1;
      end
      send(8'd4, i == 3);
    end
    @(negedge clk);
    wait_out();
    check("gap_sum", int'(bus.out_a) + int'(bus.out_b), 16);
    check("gap_count", int'(bus.out_count), 4);
    drain();

    // Reset mid-group discards partial state
    send(8'd9, 1'b0);
    send(8'd9, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    send(8'd1, 1'b0);
    send(8'd1, 1'b1);
    @(negedge clk);
    wait_out();
    check("rst_group_sum", int'(bus.out_a) + int'(bus.out_b), 2);
    check("rst_group_count", int'(bus.out_count), 2);
    drain();

    // Randomized traffic with random back-pressure and input gaps
    ready_mode = 0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_data = IN_W'($urandom);
        @(posedge clk); #1;
      end
      send(IN_W'($urandom), $urandom_range(0, 5) == 0);
    end
    ready_mode = 1;
    if (m_cnt != 0) send(IN_W'($urandom), 1'b1);
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
